// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: EX-stage request and HI/LO result bundle of the multiply/divide unit.
// The pipeline side (master) drives the request; the unit (slave) returns
// isbusy, the architectural HI/LO registers and its FSM state for debug.
//
// Handshake: a request is taken on a rising edge when start & en & ~kill and
// the unit is idle; there is no ready signal, the stall controller uses isbusy
// to keep further HI/LO-touching instructions out of EX while it is high.
interface muldiv_unit_if;
    logic        start;
    logic [2:0]  op;
    logic        en;
    logic        kill;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        isbusy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  fsm_state;

    modport master (
        output start, op, en, kill, rs_data, rt_data,
        input  isbusy, hi, lo, fsm_state
    );

    modport slave (
        input  start, op, en, kill, rs_data, rt_data,
        output isbusy, hi, lo, fsm_state
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU with HI/LO, plus MTHI/MTLO.
// Multiply is a 32-cycle shift-add and divide a 32-cycle restoring divider,
// both on operand magnitudes; signs are applied in the FIX cycle.
// Optional macro MDU_FAST_MUL_EN: multiply uses a single-cycle 64-bit '*'.
module muldiv_unit (
    input  logic           clk,
    input  logic           rst,
    muldiv_unit_if.slave   mdu
);
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIX = 2'd3} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        sign_p;     // result sign for product and quotient
    logic        sign_a;     // remainder sign, also restores rs for divide-by-zero
    logic        div_zero;
    logic        is_div;
    logic [63:0] acc;        // product accumulator, or {remainder, quotient}
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        is_signed;
    logic        is_md;
    logic        accept;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag_in;
    logic [31:0] b_mag_in;
    logic [32:0] rem_sh;
    logic        div_ge;
    logic [32:0] div_diff;
    logic [31:0] rem_next;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] rs_orig;

    // Request decode, operand magnitudes (0x80000000 negates to itself = 2^31)
    always_comb begin
        is_signed = (mdu.op == 3'd0) || (mdu.op == 3'd2);
        is_md     = (mdu.op <= 3'd3);
        accept    = mdu.start & mdu.en & ~mdu.kill & (state == IDLE);
        a_neg     = is_signed & mdu.rs_data[31];
        b_neg     = is_signed & mdu.rt_data[31];
        a_mag_in  = a_neg ? (32'd0 - mdu.rs_data) : mdu.rs_data;
        b_mag_in  = b_neg ? (32'd0 - mdu.rt_data) : mdu.rt_data;
    end

    // One restoring-division step: 33-bit partial remainder against the divisor
    always_comb begin
        rem_sh   = acc[63:31];
        div_ge   = (rem_sh >= {1'b0, b_mag});
        div_diff = rem_sh - {1'b0, b_mag};
        rem_next = div_ge ? div_diff[31:0] : rem_sh[31:0];
    end

    // Sign correction of the finished magnitudes
    always_comb begin
        prod_fix = sign_p ? (64'd0 - acc) : acc;
        quo_fix  = sign_p ? (32'd0 - acc[31:0]) : acc[31:0];
        rem_fix  = sign_a ? (32'd0 - acc[63:32]) : acc[63:32];
        rs_orig  = sign_a ? (32'd0 - a_mag) : a_mag;
    end

`ifndef MDU_FAST_MUL_EN
    logic [32:0] mul_sum;
    // One shift-add step: add a when the multiplier LSB in acc[0] is set
    always_comb begin
        mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_mag} : 33'd0);
    end
`endif

    // Control FSM with operand latches, iteration datapath and HI/LO
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 5'd0;
            a_mag    <= 32'd0;
            b_mag    <= 32'd0;
            sign_p   <= 1'b0;
            sign_a   <= 1'b0;
            div_zero <= 1'b0;
            is_div   <= 1'b0;
            acc      <= 64'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (mdu.op)
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                a_mag    <= a_mag_in;
                                b_mag    <= b_mag_in;
                                sign_p   <= a_neg ^ b_neg;
                                sign_a   <= a_neg;
                                div_zero <= (mdu.rt_data == 32'd0);
                                cnt      <= 5'd0;
                                is_div   <= mdu.op[1];
                                // multiplier starts in the low half; dividend likewise
                                acc      <= mdu.op[1] ? {32'd0, a_mag_in} : {32'd0, b_mag_in};
                                state    <= mdu.op[1] ? DIV : MUL;
                            end
                            3'd4:    hi_q <= mdu.rs_data;
                            3'd5:    lo_q <= mdu.rs_data;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
`ifdef MDU_FAST_MUL_EN
                    acc   <= {32'd0, a_mag} * {32'd0, b_mag};
                    state <= FIX;
`else
                    acc <= {mul_sum, acc[31:1]};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= FIX;
`endif
                end
                DIV: begin
                    acc <= {rem_next, acc[30:0], div_ge};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= FIX;
                end
                FIX: begin
                    if (!is_div) begin
                        hi_q <= prod_fix[63:32];
                        lo_q <= prod_fix[31:0];
                    end else if (div_zero) begin
                        hi_q <= rs_orig;
                        lo_q <= 32'hFFFF_FFFF;
                    end else begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end
                    cnt   <= 5'd0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // isbusy also covers the issuing cycle so MFHI/MFLO in ID stalls immediately
    assign mdu.isbusy    = (state != IDLE) | (mdu.start & ~mdu.kill & is_md);
    assign mdu.hi        = hi_q;
    assign mdu.lo        = lo_q;
    assign mdu.fsm_state = state;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an
// arithmetic reference model of MULT/MULTU/DIV/DIVU/MTHI/MTLO.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_unit_if mdu_if ();

    muldiv_unit dut (
        .clk (clk),
        .rst (rst),
        .mdu (mdu_if.slave)
    );

    int pass_cnt = 0;
    int tot_cnt  = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] exp_q[$];

    // Reference result {hi, lo} from plain arithmetic
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] ohi,
                                               input logic [31:0] olo);
        logic signed [31:0] sa, sb, q, r;
        logic signed [63:0] sp;
        sa = a;
        sb = b;
        case (op)
            3'd0: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return sp;
            end
            3'd1: return {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            3'd4: return {a, olo};
            3'd5: return {ohi, a};
            default: return {ohi, olo};
        endcase
    endfunction

    function automatic int exp_busy(input logic [2:0] op);
`ifdef MDU_FAST_MUL_EN
        if (op <= 3'd1) return 2;
`endif
        if (op <= 3'd3) return 33;
        return 0;
    endfunction

    task automatic idle_inputs();
        mdu_if.start   = 1'b0;
        mdu_if.op      = 3'd0;
        mdu_if.en      = 1'b1;
        mdu_if.kill    = 1'b0;
        mdu_if.rs_data = 32'd0;
        mdu_if.rt_data = 32'd0;
    endtask

    // Driver: issue one accepted op, then count busy cycles after the accept edge
    task automatic drive_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic comb_busy, output int busy, output bit held);
        logic [31:0] ohi, olo;
        @(negedge clk);
        ohi = mdu_if.hi;
        olo = mdu_if.lo;
        mdu_if.start = 1'b1; mdu_if.op = op; mdu_if.en = 1'b1; mdu_if.kill = 1'b0;
        mdu_if.rs_data = a; mdu_if.rt_data = b;
        #1 comb_busy = mdu_if.isbusy;
        @(negedge clk);
        idle_inputs();
        #1;
        busy = 0;
        held = 1'b1;
        while (mdu_if.isbusy === 1'b1 && busy < 200) begin
            if (mdu_if.hi !== ohi || mdu_if.lo !== olo) held = 1'b0;
            busy++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);
        #1;
        tot_cnt += 4;
        if (mdu_if.hi !== 32'd0) $display("FAIL reset_hi got %h want 0", mdu_if.hi); else pass_cnt++;
        if (mdu_if.lo !== 32'd0) $display("FAIL reset_lo got %h want 0", mdu_if.lo); else pass_cnt++;
        if (mdu_if.isbusy !== 1'b0) $display("FAIL reset_busy got %b want 0", mdu_if.isbusy); else pass_cnt++;
        if (mdu_if.fsm_state !== 2'd0) $display("FAIL reset_state got %0d want 0", mdu_if.fsm_state); else pass_cnt++;
        rst = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
    endtask

    task automatic test_mt();
        logic cb; int busy; bit held;
        drive_op(3'd5, 32'hDEAD_BEEF, 32'd0, cb, busy, held);
        tot_cnt += 4;
        if (cb !== 1'b0) $display("FAIL mtlo_comb_busy got %b want 0", cb); else pass_cnt++;
        if (busy != 0) $display("FAIL mtlo_busy got %0d want 0", busy); else pass_cnt++;
        if (mdu_if.lo !== 32'hDEAD_BEEF) $display("FAIL mtlo_lo got %h want deadbeef", mdu_if.lo); else pass_cnt++;
        if (mdu_if.hi !== m_hi) $display("FAIL mtlo_hi got %h want %h", mdu_if.hi, m_hi); else pass_cnt++;
        m_lo = 32'hDEAD_BEEF;
        drive_op(3'd4, 32'h0BAD_F00D, 32'd0, cb, busy, held);
        tot_cnt += 2;
        if (mdu_if.hi !== 32'h0BAD_F00D) $display("FAIL mthi_hi got %h want 0badf00d", mdu_if.hi); else pass_cnt++;
        if (mdu_if.lo !== m_lo) $display("FAIL mthi_lo got %h want %h", mdu_if.lo, m_lo); else pass_cnt++;
        m_hi = 32'h0BAD_F00D;
    endtask

    task automatic test_multu_max();
        logic cb; int busy; bit held;
        drive_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cb, busy, held);
        tot_cnt += 5;
        if (cb !== 1'b1) $display("FAIL multu_comb_busy got %b want 1", cb); else pass_cnt++;
        if (busy != exp_busy(3'd1)) $display("FAIL multu_latency got %0d want %0d", busy, exp_busy(3'd1)); else pass_cnt++;
        if (!held) $display("FAIL multu_hold got early update want hold"); else pass_cnt++;
        if (mdu_if.hi !== 32'hFFFF_FFFE) $display("FAIL multu_hi got %h want fffffffe", mdu_if.hi); else pass_cnt++;
        if (mdu_if.lo !== 32'h0000_0001) $display("FAIL multu_lo got %h want 00000001", mdu_if.lo); else pass_cnt++;
        m_hi = 32'hFFFF_FFFE;
        m_lo = 32'h0000_0001;
    endtask

    task automatic test_div_directed();
        logic [2:0]  t_op [5] = '{3'd2, 3'd3, 3'd3, 3'd2, 3'd2};
        logic [31:0] t_a  [5] = '{32'hFFFF_FFF9, 32'd100, 32'h1234_5678, 32'h8000_0000, 32'hFFFF_FFFB};
        logic [31:0] t_b  [5] = '{32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] t_hi [5] = '{32'hFFFF_FFFF, 32'd2, 32'h1234_5678, 32'd0, 32'hFFFF_FFFB};
        logic [31:0] t_lo [5] = '{32'hFFFF_FFFD, 32'd14, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        logic cb; int busy; bit held;
        for (int i = 0; i < 5; i++) begin
            drive_op(t_op[i], t_a[i], t_b[i], cb, busy, held);
            tot_cnt += 4;
            if (busy != 33) $display("FAIL div%0d_latency got %0d want 33", i, busy); else pass_cnt++;
            if (!held) $display("FAIL div%0d_hold got early update want hold", i); else pass_cnt++;
            if (mdu_if.hi !== t_hi[i]) $display("FAIL div%0d_hi got %h want %h", i, mdu_if.hi, t_hi[i]); else pass_cnt++;
            if (mdu_if.lo !== t_lo[i]) $display("FAIL div%0d_lo got %h want %h", i, mdu_if.lo, t_lo[i]); else pass_cnt++;
            m_hi = t_hi[i];
            m_lo = t_lo[i];
        end
    endtask

    task automatic test_kill();
        @(negedge clk);
        mdu_if.start = 1'b1; mdu_if.op = 3'd0; mdu_if.en = 1'b1; mdu_if.kill = 1'b1;
        mdu_if.rs_data = $urandom; mdu_if.rt_data = $urandom;
        #1;
        tot_cnt += 1;
        if (mdu_if.isbusy !== 1'b0) $display("FAIL kill_comb_busy got %b want 0", mdu_if.isbusy); else pass_cnt++;
        @(negedge clk);
        idle_inputs();
        #1;
        tot_cnt += 4;
        if (mdu_if.isbusy !== 1'b0) $display("FAIL kill_busy got %b want 0", mdu_if.isbusy); else pass_cnt++;
        if (mdu_if.fsm_state !== 2'd0) $display("FAIL kill_state got %0d want 0", mdu_if.fsm_state); else pass_cnt++;
        if (mdu_if.hi !== m_hi) $display("FAIL kill_hi got %h want %h", mdu_if.hi, m_hi); else pass_cnt++;
        if (mdu_if.lo !== m_lo) $display("FAIL kill_lo got %h want %h", mdu_if.lo, m_lo); else pass_cnt++;
    endtask

    task automatic test_en_stall();
        logic [31:0] a, b;
        logic [63:0] exp;
        int busy;
        a = 32'hFFFF_FFFD;
        b = 32'd7;
        exp = ref_result(3'd0, a, b, m_hi, m_lo);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mdu_if.start = 1'b1; mdu_if.op = 3'd0; mdu_if.en = 1'b0; mdu_if.kill = 1'b0;
            mdu_if.rs_data = a; mdu_if.rt_data = b;
            #1;
            tot_cnt += 2;
            if (mdu_if.isbusy !== 1'b1) $display("FAIL stall%0d_busy got %b want 1", i, mdu_if.isbusy); else pass_cnt++;
            if (mdu_if.fsm_state !== 2'd0) $display("FAIL stall%0d_state got %0d want 0", i, mdu_if.fsm_state); else pass_cnt++;
        end
        @(negedge clk);
        mdu_if.en = 1'b1;
        @(negedge clk);
        idle_inputs();
        #1;
        busy = 0;
        while (mdu_if.isbusy === 1'b1 && busy < 200) begin
            busy++;
            @(negedge clk);
            #1;
        end
        tot_cnt += 3;
        if (busy != exp_busy(3'd0)) $display("FAIL stall_latency got %0d want %0d", busy, exp_busy(3'd0)); else pass_cnt++;
        if (mdu_if.hi !== exp[63:32]) $display("FAIL stall_hi got %h want %h", mdu_if.hi, exp[63:32]); else pass_cnt++;
        if (mdu_if.lo !== exp[31:0]) $display("FAIL stall_lo got %h want %h", mdu_if.lo, exp[31:0]); else pass_cnt++;
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        repeat (3) @(negedge clk);
        #1;
        tot_cnt += 1;
        if (mdu_if.fsm_state !== 2'd0) $display("FAIL stall_single_op got state %0d want 0", mdu_if.fsm_state); else pass_cnt++;
    endtask

    task automatic test_ignore_busy();
        logic [63:0] exp;
        int busy;
        exp = ref_result(3'd3, 32'd1000, 32'd33, m_hi, m_lo);
        @(negedge clk);
        mdu_if.start = 1'b1; mdu_if.op = 3'd3; mdu_if.en = 1'b1; mdu_if.kill = 1'b0;
        mdu_if.rs_data = 32'd1000; mdu_if.rt_data = 32'd33;
        @(negedge clk);
        mdu_if.op = 3'd4;
        mdu_if.rs_data = 32'hCAFE_F00D;
        #1;
        busy = 0;
        while (mdu_if.isbusy === 1'b1 && busy < 200) begin
            busy++;
            if (busy == 2) idle_inputs();
            @(negedge clk);
            #1;
        end
        tot_cnt += 3;
        if (busy != 33) $display("FAIL ignore_latency got %0d want 33", busy); else pass_cnt++;
        if (mdu_if.hi !== exp[63:32]) $display("FAIL ignore_hi got %h want %h", mdu_if.hi, exp[63:32]); else pass_cnt++;
        if (mdu_if.lo !== exp[31:0]) $display("FAIL ignore_lo got %h want %h", mdu_if.lo, exp[31:0]); else pass_cnt++;
        m_hi = exp[63:32];
        m_lo = exp[31:0];
    endtask

    task automatic test_reset_mid_div();
        logic [31:0] a, b;
        logic [63:0] exp;
        logic cb; int busy; bit held;
        @(negedge clk);
        mdu_if.start = 1'b1; mdu_if.op = 3'd2; mdu_if.en = 1'b1; mdu_if.kill = 1'b0;
        mdu_if.rs_data = $urandom; mdu_if.rt_data = $urandom_range(1, 1000);
        @(negedge clk);
        idle_inputs();
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        tot_cnt += 4;
        if (mdu_if.fsm_state !== 2'd0) $display("FAIL rstdiv_state got %0d want 0", mdu_if.fsm_state); else pass_cnt++;
        if (mdu_if.isbusy !== 1'b0) $display("FAIL rstdiv_busy got %b want 0", mdu_if.isbusy); else pass_cnt++;
        if (mdu_if.hi !== 32'd0) $display("FAIL rstdiv_hi got %h want 0", mdu_if.hi); else pass_cnt++;
        if (mdu_if.lo !== 32'd0) $display("FAIL rstdiv_lo got %h want 0", mdu_if.lo); else pass_cnt++;
        rst = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        a = $urandom;
        b = $urandom;
        exp = ref_result(3'd1, a, b, m_hi, m_lo);
        drive_op(3'd1, a, b, cb, busy, held);
        tot_cnt += 3;
        if (busy != exp_busy(3'd1)) $display("FAIL rstdiv_mul_latency got %0d want %0d", busy, exp_busy(3'd1)); else pass_cnt++;
        if (mdu_if.hi !== exp[63:32]) $display("FAIL rstdiv_mul_hi got %h want %h", mdu_if.hi, exp[63:32]); else pass_cnt++;
        if (mdu_if.lo !== exp[31:0]) $display("FAIL rstdiv_mul_lo got %h want %h", mdu_if.lo, exp[31:0]); else pass_cnt++;
        m_hi = exp[63:32];
        m_lo = exp[31:0];
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b, e_hi, e_lo;
        logic [63:0] exp;
        logic cb; int busy; bit held;
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 5));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            exp = ref_result(op, a, b, m_hi, m_lo);
            exp_q.push_back(exp[63:32]);
            exp_q.push_back(exp[31:0]);
            drive_op(op, a, b, cb, busy, held);
            e_hi = exp_q.pop_front();
            e_lo = exp_q.pop_front();
            tot_cnt += 4;
            if (busy != exp_busy(op)) $display("FAIL rnd%0d_latency op %0d got %0d want %0d", i, op, busy, exp_busy(op)); else pass_cnt++;
            if (!held) $display("FAIL rnd%0d_hold op %0d got early update want hold", i, op); else pass_cnt++;
            if (mdu_if.hi !== e_hi) $display("FAIL rnd%0d_hi op %0d a %h b %h got %h want %h", i, op, a, b, mdu_if.hi, e_hi); else pass_cnt++;
            if (mdu_if.lo !== e_lo) $display("FAIL rnd%0d_lo op %0d a %h b %h got %h want %h", i, op, a, b, mdu_if.lo, e_lo); else pass_cnt++;
            m_hi = e_hi;
            m_lo = e_lo;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mt();
        test_multu_max();
        test_div_directed();
        test_kill();
        test_en_stall();
        test_ignore_busy();
        test_reset_mid_div();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
